// File: rtl/pcm_sample_fifo.sv
// PCM sample FIFO: circular buffer between the CIC decimator and bus reader.
// Define PCM_FIFO_DCBLOCK_EN to insert a DC-blocking high-pass ahead of it.
module pcm_sample_fifo #(
   parameter int DEPTH = 16,
   parameter int LW    = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic signed [15:0]  pcm_in,
   input  logic                pcm_in_valid,
   input  logic                rd_en,
   output logic signed [15:0]  rd_data,
   output logic                empty,
   output logic                full,
   output logic [LW-1:0]       level,
   input  logic [LW-1:0]       threshold,
   output logic                irq,
   output logic                overflow,
   input  logic                clr_overflow
);

   localparam int AW = $clog2(DEPTH);

   logic signed [15:0] mem_q [DEPTH];
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]      level_q, level_d;
   logic               empty_q, empty_d;
   logic               full_q, full_d;
   logic               ovf_q, ovf_d;
   logic               wr_stb;
   logic signed [15:0] wr_data;
   logic               push, pop;

`ifdef PCM_FIFO_DCBLOCK_EN
   logic signed [21:0] x_prev_q;
   logic signed [21:0] y_q;
   logic               stb_q;
   logic signed [21:0] x_ext;
   logic signed [21:0] y_d;

   assign x_ext = {{6{pcm_in[15]}}, pcm_in};
   assign y_d   = x_ext - x_prev_q + y_q - (y_q >>> 5);

   always_ff @(posedge clk) begin
      if (rst) begin
         x_prev_q <= '0;
         y_q      <= '0;
         stb_q    <= 1'b0;
      end else begin
         stb_q <= pcm_in_valid;
         if (pcm_in_valid) begin
            x_prev_q <= x_ext;
            y_q      <= y_d;
         end
      end
   end

   // State keeps full precision; only the stored sample is clamped.
   always_comb begin
      wr_data = y_q[15:0];
      if (y_q > 22'sd32767) begin
         wr_data = 16'sh7fff;
      end else if (y_q < -22'sd32768) begin
         wr_data = 16'sh8000;
      end
   end

   assign wr_stb = stb_q;
`else
   assign wr_stb  = pcm_in_valid;
   assign wr_data = pcm_in;
`endif

   // A full FIFO still accepts a push when the head leaves the same edge.
   assign pop  = rd_en & ~empty_q;
   assign push = wr_stb & (~full_q | rd_en);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      ovf_d    = ovf_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      empty_d = (level_d == '0);
      full_d  = (level_d == LW'(DEPTH));
      if (wr_stb && full_q && !rd_en) begin
         ovf_d = 1'b1;
      end else if (clr_overflow) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   assign rd_data  = mem_q[rd_ptr_q];
   assign empty    = empty_q;
   assign full     = full_q;
   assign level    = level_q;
   assign overflow = ovf_q;
   assign irq      = (threshold != '0) && (level_q >= threshold);

endmodule

// File: tb/tb_pcm_sample_fifo.sv
// Self-checking bench for pcm_sample_fifo (default build, no DC blocker),
// compared against a queue-based reference model.
module tb_pcm_sample_fifo;

   localparam int DEPTH = 16;
   localparam int LW    = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic [15:0]   pcm_in;
   logic          pcm_in_valid;
   logic          rd_en;
   logic [15:0]   rd_data;
   logic          empty;
   logic          full;
   logic [LW-1:0] level;
   logic [LW-1:0] threshold;
   logic          irq;
   logic          overflow;
   logic          clr_overflow;

   int passed = 0;
   int total  = 0;

   logic [15:0] q[$];
   bit          ovf_m;

   pcm_sample_fifo #(.DEPTH(DEPTH), .LW(LW)) dut (
      .clk          (clk),
      .rst          (rst),
      .pcm_in       (pcm_in),
      .pcm_in_valid (pcm_in_valid),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .empty        (empty),
      .full         (full),
      .level        (level),
      .threshold    (threshold),
      .irq          (irq),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // One clock with the given inputs; the model follows the behavioural rules.
   task automatic cyc(bit v, logic [15:0] d, bit rd, bit clr, bit r);
      bit do_pop, do_push;
      rst          = r;
      pcm_in_valid = v;
      pcm_in       = d;
      rd_en        = rd;
      clr_overflow = clr;
      do_pop  = rd && q.size() > 0;
      do_push = v && (q.size() < DEPTH || do_pop);
      @(posedge clk);
      #1;
      if (r) begin
         q.delete();
         ovf_m = 0;
      end else begin
         if (v && q.size() == DEPTH && !rd) ovf_m = 1;
         else if (clr) ovf_m = 0;
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back(d);
      end
      rst          = 1'b0;
      pcm_in_valid = 1'b0;
      rd_en        = 1'b0;
      clr_overflow = 1'b0;
   endtask

   task automatic check_all(string tag);
      int  n;
      bit  irq_m;
      n     = q.size();
      irq_m = (threshold != 0) && (n >= threshold);
      chk({tag, ".level"}, level, n);
      chk({tag, ".empty"}, empty, n == 0);
      chk({tag, ".full"}, full, n == DEPTH);
      chk({tag, ".ovf"}, overflow, ovf_m);
      chk({tag, ".irq"}, irq, irq_m);
      if (n > 0) chk({tag, ".data"}, rd_data, q[0]);
   endtask

   initial begin
      rst = 1'b1; pcm_in = '0; pcm_in_valid = 1'b0; rd_en = 1'b0;
      clr_overflow = 1'b0; threshold = '0; ovf_m = 0;
      cyc(1, 16'h1234, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      check_all("reset");

      cyc(1, 16'd100, 0, 0, 0);
      check_all("lat1");
      cyc(1, -16'sd200, 0, 0, 0);
      cyc(1, 16'd300, 0, 0, 0);
      check_all("three");
      chk("three.head", rd_data, 16'd100);
      repeat (3) begin
         cyc(0, 0, 1, 0, 0);
         check_all("pop3");
      end
      chk("pop3.empty", empty, 1'b1);
      cyc(0, 0, 1, 0, 0);
      check_all("pop_empty");

      for (int i = 0; i < 17; i++) begin
         cyc(1, 16'(1000 + i), 0, 0, 0);
      end
      check_all("fill17");
      chk("fill17.ovf", overflow, 1'b1);
      chk("fill17.lvl", level, 5'd16);
      cyc(0, 0, 0, 1, 0);
      check_all("clr");
      cyc(1, 16'h7777, 0, 1, 0);
      check_all("setclr");

      cyc(0, 0, 0, 1, 0);
      cyc(1, 16'hbeef, 1, 0, 0);
      check_all("fullpp");
      chk("fullpp.head", rd_data, 16'd1001);
      for (int i = 0; i < DEPTH; i++) begin
         cyc(0, 0, 1, 0, 0);
         check_all("drain");
      end

      threshold = 5'd4;
      for (int i = 0; i < 4; i++) begin
         cyc(1, 16'(i * 7), 0, 0, 0);
         check_all("thr4");
      end
      chk("thr4.irq", irq, 1'b1);
      cyc(0, 0, 1, 0, 0);
      chk("thr4.pop", irq, 1'b0);
      threshold = 5'd0;
      #1 check_all("thr0");
      threshold = 5'd20;
      #1 check_all("thr20");
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
      check_all("empty2");

      cyc(1, 16'h5a5a, 1, 0, 0);
      check_all("epp");
      chk("epp.data", rd_data, 16'h5a5a);
      for (int i = 0; i < 40; i++) begin
         cyc(1, 16'($urandom), 1, 0, 0);
         check_all("wrap");
      end
      cyc(0, 0, 1, 0, 0);
      check_all("wrap_end");

      for (int i = 0; i < 600; i++) begin
         if (i % 100 == 0) threshold = LW'($urandom_range(0, 20));
         cyc(($urandom % 4) < (i < 300 ? 3 : 1), 16'($urandom),
             ($urandom % 4) < (i < 300 ? 1 : 3),
             ($urandom % 16) == 0, 0);
         check_all("rand");
      end

      for (int i = 0; i < 5; i++) cyc(1, 16'($urandom), 0, 0, 0);
      cyc(1, 16'h4444, 0, 0, 1);
      check_all("midrst");
      chk("midrst.empty", empty, 1'b1);
      cyc(1, 16'h2222, 0, 0, 0);
      check_all("postrst");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/pcm_sample_fifo.md
PCM_SAMPLE_FIFO -- requirements
Module: pcm_sample_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of sample entries (power of two, 4..64).
REQ-002 SHALL have parameter LW, default 5, width of level output (log2(DEPTH)+1).
REQ-003 SHALL have port clk  input  1  PDM-domain clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port pcm_in  input  16  signed decimated sample from the CIC stage.
REQ-006 SHALL have port pcm_in_valid  input  1  single-cycle strobe qualifying pcm_in.
REQ-007 SHALL have port rd_en  input  1  pop request from the bus-side reader.
REQ-008 SHALL have port rd_data  output  16  signed head-of-FIFO sample (first-word-fall-through).
REQ-009 SHALL have port empty  output  1  FIFO holds zero samples.
REQ-010 SHALL have port full  output  1  FIFO holds DEPTH samples.
REQ-011 SHALL have port level  output  LW  current sample count, 0..DEPTH.
REQ-012 SHALL have port threshold  input  LW  interrupt level; 0 disables irq.
REQ-013 SHALL have port irq  output  1  level-sensitive data-ready interrupt.
REQ-014 SHALL have port overflow  output  1  sticky sample-dropped flag.
REQ-015 SHALL have port clr_overflow  input  1  single-cycle clear of overflow.

Function
REQ-016 SHALL be a circular buffer: write and read pointers wrap modulo DEPTH; level tracked in a separate counter.
REQ-017 Push (store sample, wr_ptr+1, level+1) SHALL occur on the edge where the write-path strobe is high and full is low.
REQ-018 Pop (rd_ptr+1, level-1) SHALL occur on the edge where rd_en is high and empty is low; rd_en while empty is ignored.
REQ-019 rd_data SHALL equal the entry at rd_ptr whenever empty is low; value is don't-care when empty.
REQ-020 Push and pop in the same cycle with 0<level<DEPTH SHALL leave level unchanged, both pointers advance.
REQ-021 When full, a simultaneous pop and push SHALL both succeed (no overflow, level stays DEPTH).
REQ-022 When empty, a simultaneous push and pop SHALL perform push only (level becomes 1).
REQ-023 Push attempt while full with no pop SHALL drop the new sample, leave storage untouched, set overflow.
REQ-024 overflow SHALL stay set until clr_overflow; same-cycle set and clear SHALL leave it set.
REQ-025 empty, full, level SHALL be registered outputs updated on the push/pop edge.
REQ-026 irq SHALL be high iff threshold != 0 and level >= threshold; thresholds above DEPTH never assert.
REQ-027 Write latency without filter: sample strobed at edge N appears on rd_data and empty falls after edge N.

Reset
REQ-028 rst SHALL clear pointers, level=0, empty=1, full=0, overflow=0, irq=0, and all filter state.
REQ-029 rst mid-operation SHALL discard all stored and in-flight samples; storage RAM contents need not clear.
REQ-030 A pcm_in_valid coincident with rst SHALL be ignored.

Configuration
REQ-031 Macro PCM_FIFO_DCBLOCK_EN SHALL, when defined, insert a DC-blocking high-pass before the FIFO.
REQ-032 With it: y[n] = x[n] - x[n-1] + y[n-1] - (y[n-1] >>> 5), 22-bit signed state, arithmetic shift.
REQ-033 With it: stored sample = y[n] saturated to [-32768, 32767]; state keeps unsaturated y.
REQ-034 With it: filter registers y on each pcm_in_valid and presents it as a one-cycle push strobe next cycle (+1 cycle latency); filter state updates even if that push is later dropped as overflow.
REQ-035 Without it: pcm_in stored unmodified, no filter registers present, latency per REQ-027.

Verification
REQ-036 Reset, push 3 samples 100,-200,300 (no filter) -> level=3, rd_data=100; pop x3 yields 100,-200,300 then empty=1.
REQ-037 DEPTH=16: push 17 with no pops -> full=1, level=16, overflow=1, 17th value absent; clr_overflow -> overflow=0.
REQ-038 Full FIFO, push+pop same cycle -> level=16, overflow=0, popped value = oldest, new value at tail.
REQ-039 threshold=4: pushes to level 3 -> irq=0; 4th push -> irq=1; one pop -> irq=0; threshold=0 -> irq=0 at any level.
REQ-040 Empty FIFO, rd_en with push same cycle -> level=1, rd_data=pushed value; 40 push/pop pairs -> pointer wrap, data order intact.
REQ-041 PCM_FIFO_DCBLOCK_EN: constant input 1000 -> first stored 1000, outputs decay monotonically toward 0 (|y|<32 after 200 samples); step 32767 after -32768 saturates to 32767.
